// File: rtl/tpu_thread_rcv.sv
// TPU-side thread receiver: takes a header plus instruction beats, fills IMEM, starts the sequencer, returns commit.
// Optional macro TPU_RCV_LENCHK_EN adds a sticky O_Err for out-of-range header lengths.
module tpu_thread_rcv #(
  parameter int WIDTH_INSTR     = 64,
  parameter int WIDTH_ID        = 16,
  parameter int WIDTH_NUM_ISSUE = 4,
  parameter int DEPTH_IMEM      = 1024,
  parameter int WIDTH_IADDR     = $clog2(DEPTH_IMEM)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Valid,
  input  logic [WIDTH_INSTR-1:0]     I_Data,
  output logic                       O_Ready,
  output logic                       O_IMem_We,
  output logic [WIDTH_IADDR-1:0]     O_IMem_Addr,
  output logic [WIDTH_INSTR-1:0]     O_IMem_Data,
  output logic                       O_Start,
  output logic [WIDTH_ID-1:0]        O_ThreadID,
  output logic [WIDTH_IADDR:0]       O_Length,
  input  logic                       I_End,
  output logic                       O_Commit,
  output logic [WIDTH_NUM_ISSUE-1:0] O_IssueNo,
`ifdef TPU_RCV_LENCHK_EN
  output logic                       O_Err,
`endif
  output logic                       O_Busy
);

  // state      | meaning
  // RCV_INIT   | idle, waiting for a header beat
  // RCV_INSTRS | receiving instruction beats into IMEM
  // RCV_START  | one-cycle start pulse to the sequencer
  // RCV_RUN    | thread executing, waiting for I_End
  // RCV_COMMIT | one-cycle commit pulse with issue number
  typedef enum logic [2:0] {
    RCV_INIT,
    RCV_INSTRS,
    RCV_START,
    RCV_RUN,
    RCV_COMMIT
  } rcv_state_t;

  localparam logic [WIDTH_IADDR:0] LP_ONE     = (WIDTH_IADDR+1)'(1);
  localparam logic [WIDTH_IADDR:0] LP_DEPTH   = (WIDTH_IADDR+1)'(DEPTH_IMEM);
  localparam logic [31:0]          LP_DEPTH32 = 32'(DEPTH_IMEM);

  rcv_state_t                 r_state;
  logic [WIDTH_IADDR:0]       r_cnt;
  logic [WIDTH_IADDR:0]       r_len;
  logic [WIDTH_ID-1:0]        r_id;
  logic [WIDTH_NUM_ISSUE-1:0] r_issue;
  logic                       r_start;
  logic                       r_commit;
  logic                       r_busy;
`ifdef TPU_RCV_LENCHK_EN
  logic                       r_err;
  logic                       w_len_bad;
`endif

  logic                       w_xfer;
  logic                       w_last;
  logic [15:0]                w_hdr_len;
  logic [31:0]                w_len_ext;
  logic [WIDTH_IADDR:0]       w_len_eff;

  assign O_Ready   = (r_state == RCV_INIT) || (r_state == RCV_INSTRS);
  assign w_xfer    = I_Valid && O_Ready;
  assign w_last    = (r_cnt == (r_len - LP_ONE));
  assign w_hdr_len = I_Data[15:0];
  assign w_len_ext = {16'd0, w_hdr_len};

  // Zero length still loads one beat; oversize lengths are clamped to the IMEM depth.
  always_comb begin
    w_len_eff = (WIDTH_IADDR+1)'(w_hdr_len);
    if (w_hdr_len == 16'd0)
      w_len_eff = LP_ONE;
    else if (w_len_ext > LP_DEPTH32)
      w_len_eff = LP_DEPTH;
  end

`ifdef TPU_RCV_LENCHK_EN
  assign w_len_bad = (w_hdr_len == 16'd0) || (w_len_ext > LP_DEPTH32);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= RCV_INIT;
      r_cnt    <= '0;
      r_len    <= '0;
      r_id     <= '0;
      r_issue  <= '0;
      r_start  <= 1'b0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
`ifdef TPU_RCV_LENCHK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_start  <= 1'b0;
      r_commit <= 1'b0;
      case (r_state)
        RCV_INIT: begin
          if (w_xfer) begin
`ifdef TPU_RCV_LENCHK_EN
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_id    <= I_Data[32 +: WIDTH_ID];
              r_issue <= I_Data[16 +: WIDTH_NUM_ISSUE];
              r_len   <= w_len_eff;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= RCV_INSTRS;
            end
`else
            r_id    <= I_Data[32 +: WIDTH_ID];
            r_issue <= I_Data[16 +: WIDTH_NUM_ISSUE];
            r_len   <= w_len_eff;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RCV_INSTRS;
`endif
          end
        end
        RCV_INSTRS: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + LP_ONE;
            if (w_last) begin
              r_start <= 1'b1;
              r_state <= RCV_START;
            end
          end
        end
        RCV_START: begin
          r_state <= RCV_RUN;
        end
        RCV_RUN: begin
          if (I_End) begin
            r_commit <= 1'b1;
            r_state  <= RCV_COMMIT;
          end
        end
        RCV_COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= RCV_INIT;
        end
        default: begin
          r_state <= RCV_INIT;
        end
      endcase
    end
  end

  assign O_IMem_We   = (r_state == RCV_INSTRS) && I_Valid;
  assign O_IMem_Addr = O_IMem_We ? r_cnt[WIDTH_IADDR-1:0] : '0;
  assign O_IMem_Data = O_IMem_We ? I_Data : '0;
  assign O_Start     = r_start;
  assign O_Commit    = r_commit;
  assign O_ThreadID  = r_id;
  assign O_Length    = r_len;
  assign O_IssueNo   = r_issue;
  assign O_Busy      = r_busy;
`ifdef TPU_RCV_LENCHK_EN
  assign O_Err       = r_err;
`endif

endmodule

// File: tb/tb_tpu_thread_rcv.sv
// Scoreboard bench for tpu_thread_rcv: driver pushes expected IMEM writes, starts and commits; monitor pops and compares.
module tb_tpu_thread_rcv;
  localparam int W     = 64;
  localparam int WID   = 16;
  localparam int WNI   = 4;
  localparam int DEPTH = 1024;
  localparam int WA    = $clog2(DEPTH);

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           I_Valid = 1'b0;
  logic [W-1:0]   I_Data = '0;
  logic           I_End = 1'b0;
  logic           O_Ready, O_IMem_We, O_Start, O_Commit, O_Busy;
  logic [WA-1:0]  O_IMem_Addr;
  logic [W-1:0]   O_IMem_Data;
  logic [WID-1:0] O_ThreadID;
  logic [WA:0]    O_Length;
  logic [WNI-1:0] O_IssueNo;
`ifdef TPU_RCV_LENCHK_EN
  logic           O_Err;
`endif

  tpu_thread_rcv dut (
    .clock(clock), .reset(reset), .I_Valid(I_Valid), .I_Data(I_Data), .O_Ready(O_Ready),
    .O_IMem_We(O_IMem_We), .O_IMem_Addr(O_IMem_Addr), .O_IMem_Data(O_IMem_Data),
    .O_Start(O_Start), .O_ThreadID(O_ThreadID), .O_Length(O_Length), .I_End(I_End),
    .O_Commit(O_Commit), .O_IssueNo(O_IssueNo),
`ifdef TPU_RCV_LENCHK_EN
    .O_Err(O_Err),
`endif
    .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [WA-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { logic [WID-1:0] id; logic [WA:0] len; int cyc; } st_t;
  typedef struct { logic [WNI-1:0] issue; logic [WID-1:0] id; int cyc; } cm_t;
  wr_t q_wr[$];
  st_t q_st[$];
  cm_t q_cm[$];

  // Reference model: the thread currently being loaded.
  logic [WID-1:0] m_id;
  logic [WNI-1:0] m_iss;
  logic [WA:0]    m_len;

  wr_t mw;
  st_t ms;
  cm_t mc;
  always @(negedge clock) begin
    if (reset) begin
      if (O_IMem_We) begin
        chk("we_only_with_valid", I_Valid, 1);
        chk("write_expected", q_wr.size() > 0, 1);
        if (q_wr.size() > 0) begin
          mw = q_wr.pop_front();
          chk("imem_addr", O_IMem_Addr, mw.addr);
          chk("imem_data", O_IMem_Data, mw.data);
        end
      end
      if (O_Start) begin
        chk("start_expected", q_st.size() > 0, 1);
        if (q_st.size() > 0) begin
          ms = q_st.pop_front();
          chk("start_id", O_ThreadID, ms.id);
          chk("start_len", O_Length, ms.len);
          chk("start_cycle", cyc, ms.cyc);
          chk("start_busy", O_Busy, 1);
        end
      end
      if (O_Commit) begin
        chk("commit_expected", q_cm.size() > 0, 1);
        if (q_cm.size() > 0) begin
          mc = q_cm.pop_front();
          chk("commit_issue", O_IssueNo, mc.issue);
          chk("commit_id_held", O_ThreadID, mc.id);
          chk("commit_cycle", cyc, mc.cyc);
          chk("commit_busy", O_Busy, 1);
        end
      end
    end
  end

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_total);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not end, expected finish");
    summary();
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] mk_hdr(input logic [15:0] id, input logic [3:0] iss, input logic [15:0] len);
    return {16'($urandom), id, 12'($urandom), iss, len};
  endfunction

  task automatic set_model(input logic [15:0] id, input logic [3:0] iss, input logic [15:0] len);
    int eff;
    eff = (len == 0) ? 1 : ((int'(len) > DEPTH) ? DEPTH : int'(len));
    m_id = id;
    m_iss = iss;
    m_len = (WA+1)'(eff);
  endtask

  task automatic send_beat(input logic [W-1:0] d, output int xc);
    bit got;
    got = 0;
    xc = -1;
    I_Valid = 1'b1;
    I_Data = d;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      got = O_Ready;
      xc = cyc;
      @(posedge clock);
      #1;
    end
    if (!got) chk("beat_accept_timeout", got, 1);
  endtask

  task automatic send_hdr(input logic [15:0] id, input logic [3:0] iss, input logic [15:0] len, output int xc);
    send_beat(mk_hdr(id, iss, len), xc);
    set_model(id, iss, len);
  endtask

  // mode 0: continuous, 1: one idle cycle between beats, 2: random 0..3 idle cycles
  task automatic send_body(input int n, input int mode, input bit fixed_data);
    int xc, gap;
    logic [W-1:0] d;
    wr_t w;
    for (int i = 0; i < n; i++) begin
      gap = (mode == 1 && i > 0) ? 1 : (mode == 2 ? int'($urandom_range(0, 3)) : 0);
      if (gap > 0) begin
        I_Valid = 1'b0;
        I_Data = {$urandom, $urandom};
        repeat (gap) tick();
      end
      d = fixed_data ? W'((i + 1) * 'h11) : {$urandom, $urandom};
      w.addr = WA'(i);
      w.data = d;
      q_wr.push_back(w);
      send_beat(d, xc);
      if (i == n - 1 && n == int'(m_len)) begin
        st_t s;
        s.id = m_id; s.len = m_len; s.cyc = xc + 1;
        q_st.push_back(s);
      end
    end
    I_Valid = 1'b0;
  endtask

  // Called in the start cycle; pulses I_End `dly` cycles later and returns in RCV_INIT.
  task automatic end_thread(input int dly);
    cm_t c;
    repeat (dly) tick();
    I_End = 1'b1;
    c.issue = m_iss; c.id = m_id; c.cyc = cyc + 1;
    q_cm.push_back(c);
    tick();
    I_End = 1'b0;
    tick();
    chk("busy_idle_after_commit", O_Busy, 0);
    chk("ready_after_commit", O_Ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, O_Ready, 1);
    chk({tag, "_we"}, O_IMem_We, 0);
    chk({tag, "_addr"}, O_IMem_Addr, 0);
    chk({tag, "_data"}, O_IMem_Data, 0);
    chk({tag, "_start"}, O_Start, 0);
    chk({tag, "_commit"}, O_Commit, 0);
    chk({tag, "_busy"}, O_Busy, 0);
    chk({tag, "_id"}, O_ThreadID, 0);
    chk({tag, "_len"}, O_Length, 0);
    chk({tag, "_issue"}, O_IssueNo, 0);
`ifdef TPU_RCV_LENCHK_EN
    chk({tag, "_err"}, O_Err, 0);
`endif
  endtask

  initial begin
    int xc, ec;
    logic [15:0] rid;
    logic [W-1:0] hb;

    // Reset state with valid asserted and junk data
    I_Valid = 1'b1;
    I_Data = {$urandom, $urandom};
    #23;
    check_reset_vals("reset");
    I_Valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Directed thread, continuous beats
    send_hdr(16'h00A5, 4'd3, 16'd4, xc);
    send_body(4, 0, 1'b1);
    end_thread(10);

    // Same thread with valid toggling
    send_hdr(16'h00A5, 4'd3, 16'd4, xc);
    send_body(4, 1, 1'b1);
    end_thread(3);

    // Header offered while running is held off until after commit
    send_hdr(16'h0111, 4'd7, 16'd3, xc);
    send_body(3, 0, 1'b0);
    hb = mk_hdr(16'h0222, 4'd9, 16'd2);
    I_Valid = 1'b1;
    I_Data = hb;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("ready_low_while_running", O_Ready, 0);
      chk("id_not_relatched", O_ThreadID, 16'h0111);
      tick();
    end
    I_End = 1'b1;
    ec = cyc;
    begin
      cm_t c;
      c.issue = m_iss; c.id = m_id; c.cyc = ec + 1;
      q_cm.push_back(c);
    end
    tick();
    I_End = 1'b0;
    send_beat(hb, xc);
    chk("hdr_accept_after_commit", xc, ec + 2);
    chk("new_id_after_accept", O_ThreadID, 16'h0222);
    set_model(16'h0222, 4'd9, 16'd2);
    send_body(2, 0, 1'b0);
    end_thread(2);

    // Full-depth thread
    send_hdr(16'hBEEF, 4'd15, 16'(DEPTH), xc);
    send_body(DEPTH, 0, 1'b0);
    end_thread(1);

    // Reset mid-stream after 2 of 4 beats
    send_hdr(16'h0C0C, 4'd5, 16'd4, xc);
    send_body(2, 0, 1'b0);
    I_Valid = 1'b1;
    I_Data = {$urandom, $urandom};
    reset = 1'b0;
    #2;
    check_reset_vals("midreset");
    tick();
    I_Valid = 1'b0;
    reset = 1'b1;
    repeat (4) tick();
    send_hdr(16'h0D0D, 4'd6, 16'd4, xc);
    send_body(4, 0, 1'b0);
    end_thread(2);

    // Randomized threads
    for (int t = 0; t < 6; t++) begin
      rid = 16'($urandom);
      send_hdr(rid, 4'($urandom), 16'($urandom_range(1, 24)), xc);
      send_body(int'(m_len), 2, 1'b0);
      end_thread(int'($urandom_range(1, 8)));
    end

`ifdef TPU_RCV_LENCHK_EN
    // Bad lengths are consumed, flag the error and start nothing
    send_beat(mk_hdr(16'h0BAD, 4'd1, 16'd0), xc);
    I_Valid = 1'b0;
    repeat (3) tick();
    chk("err_len0", O_Err, 1);
    chk("err_len0_ready", O_Ready, 1);
    chk("err_len0_busy", O_Busy, 0);
    send_beat(mk_hdr(16'h0BAE, 4'd2, 16'd3000), xc);
    I_Valid = 1'b0;
    repeat (3) tick();
    chk("err_sticky", O_Err, 1);
    send_hdr(16'h0600, 4'd4, 16'd3, xc);
    send_body(3, 0, 1'b0);
    end_thread(2);
    chk("err_still_sticky", O_Err, 1);
`else
    // Zero length loads one beat; oversize length is clamped
    send_hdr(16'h0400, 4'd8, 16'd0, xc);
    chk("len0_model_eff", m_len, 1);
    send_body(1, 0, 1'b0);
    end_thread(2);
    send_hdr(16'h0500, 4'd10, 16'd2000, xc);
    send_body(DEPTH, 0, 1'b0);
    end_thread(2);
`endif

    repeat (5) tick();
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("start_queue_drained", q_st.size(), 0);
    chk("commit_queue_drained", q_cm.size(), 0);
    summary();
    $finish;
  end

endmodule
